// File: rtl/bdb_pkg.sv
// Shared types for the debounced-counter result producer.
// Record layout and debounce FSM states.
package bdb_pkg;

    localparam int BDB_COUNT_WIDTH = 8;

    typedef struct packed {
        logic [BDB_COUNT_WIDTH-1:0] count;
    } bdb_result_t;

    typedef enum logic {
        ST_STABLE,
        ST_COUNTING
    } bdb_deb_state_t;

endpackage

// File: rtl/bdb_result_producer_if.sv
// Valid/ready result channel carrying press counts.
// Producer side is master, consumer side is slave.
interface bdb_result_producer_if;
    import bdb_pkg::*;

    logic                       result_valid;
    logic                       result_ready;
    logic [BDB_COUNT_WIDTH-1:0] result_count;

    modport master (
        output result_valid,
        output result_count,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_count,
        output result_ready
    );

endinterface

// File: rtl/bdb_result_fifo.sv
// Synchronous record FIFO with wrap-bit pointers.
// Head comes straight from register storage; zero when empty.
module bdb_result_fifo
    import bdb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr_en,
    input  bdb_result_t i_wr_data,
    output logic        o_full,
    input  logic        i_rd_en,
    output logic        o_empty,
    output bdb_result_t o_head
);

    localparam int AW = $clog2(DEPTH);

    bdb_result_t r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_empty;
    logic        w_full;
    logic        w_do_rd;
    logic        w_do_wr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A write into a full FIFO succeeds only when a pop frees a slot.
    assign w_do_rd = i_rd_en && !w_empty;
    assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance on accepted write / read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Record storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/bdb_result_producer.sv
// Button synchroniser, debouncer and press counter.
// Each debounced press is queued as a result record.
module bdb_result_producer
    import bdb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int COUNT_WIDTH     = BDB_COUNT_WIDTH,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         button_raw,
    output logic                         debounced,
    output logic                         dropped,
    bdb_result_producer_if.master        res
);

    localparam int SW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [SW-1:0] LAST = SW'(DEBOUNCE_CYCLES - 1);

    logic                   r_sync1;
    logic                   r_sync2;
    bdb_deb_state_t         r_state;
    bdb_deb_state_t         w_state_nxt;
    logic [SW-1:0]          r_stab;
    logic [SW-1:0]          w_stab_nxt;
    logic                   r_deb;
    logic                   w_deb_nxt;
    logic                   w_diff;
    logic                   w_rise;
    logic [COUNT_WIDTH-1:0] r_press;
    logic [COUNT_WIDTH-1:0] w_press_inc;
    logic                   r_dropped;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    bdb_result_t            w_rec;
    bdb_result_t            w_head;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= button_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_diff = (r_sync2 != r_deb);

    // Debounce FSM state, stability count and debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STABLE;
            r_stab  <= '0;
            r_deb   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stab  <= w_stab_nxt;
            r_deb   <= w_deb_nxt;
        end
    end

    // Any cycle of agreement restarts the stability count.
    always_comb begin
        w_state_nxt = r_state;
        w_stab_nxt  = r_stab;
        w_deb_nxt   = r_deb;
        unique case (r_state)
            ST_STABLE: begin
                w_stab_nxt = '0;
                if (w_diff) begin
                    if (r_stab == LAST) begin
                        w_deb_nxt = r_sync2;
                    end else begin
                        w_stab_nxt  = r_stab + 1'b1;
                        w_state_nxt = ST_COUNTING;
                    end
                end
            end
            ST_COUNTING: begin
                if (!w_diff) begin
                    w_stab_nxt  = '0;
                    w_state_nxt = ST_STABLE;
                end else if (r_stab == LAST) begin
                    w_deb_nxt   = r_sync2;
                    w_stab_nxt  = '0;
                    w_state_nxt = ST_STABLE;
                end else begin
                    w_stab_nxt = r_stab + 1'b1;
                end
            end
            default: begin
                w_stab_nxt  = '0;
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    assign w_rise      = w_deb_nxt & ~r_deb;
    assign w_press_inc = r_press + 1'b1;
    assign w_rec.count = w_press_inc;
    assign w_pop       = res.result_valid && res.result_ready;

    // Press counter wraps naturally; drop flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_press   <= '0;
            r_dropped <= 1'b0;
        end else if (w_rise) begin
            r_press <= w_press_inc;
            if (w_full && !w_pop) r_dropped <= 1'b1;
        end
    end

    bdb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_rise),
        .i_wr_data (w_rec),
        .o_full    (w_full),
        .i_rd_en   (w_pop),
        .o_empty   (w_empty),
        .o_head    (w_head)
    );

    assign res.result_valid = !w_empty;
    assign res.result_count = w_head.count;
    assign debounced        = r_deb;
    assign dropped          = r_dropped;

endmodule

// File: tb/tb_bdb_result_producer.sv
// Directed bench for bdb_result_producer.
// DEBOUNCE_CYCLES=8, FIFO_DEPTH=4, COUNT_WIDTH=8.
module tb_bdb_result_producer;
    import bdb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic button_raw;
    logic debounced;
    logic dropped;
    int   total = 0;
    int   bad = 0;
    int   got[$];

    bdb_result_producer_if bus ();

    bdb_result_producer #(
        .DEBOUNCE_CYCLES (8),
        .COUNT_WIDTH     (8),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button_raw (button_raw),
        .debounced  (debounced),
        .dropped    (dropped),
        .res        (bus)
    );

    always #5 clk = ~clk;

    // Record every accepted transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && bus.result_valid && bus.result_ready)
            got.push_back(int'(bus.result_count));
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press();
        button_raw = 1'b1;
        tick(12);
        button_raw = 1'b0;
        tick(12);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        got.delete();
    endtask

    function automatic int qget(input int idx);
        if (idx < got.size()) return got[idx];
        return -1;
    endfunction

    int rise_at;
    int seen_hi;
    int nerr;

    initial begin
        reset = 1'b1;
        button_raw = 1'b0;
        bus.result_ready = 1'b0;
        tick(3);
        reset = 1'b0;

        // 1: idle after reset
        chk("t1_count", int'(bus.result_count), 0);
        for (int i = 0; i < 20; i++) begin
            chk("t1_deb", int'(debounced), 0);
            chk("t1_valid", int'(bus.result_valid), 0);
            chk("t1_drop", int'(dropped), 0);
            tick(1);
        end

        // 2: latency of a clean press
        got.delete();
        bus.result_ready = 1'b1;
        button_raw = 1'b1;
        rise_at = 0;
        for (int n = 1; n <= 20; n++) begin
            tick(1);
            if (debounced && rise_at == 0) rise_at = n;
        end
        chk("t2_latency", rise_at, 10);
        chk("t2_nrec", got.size(), 1);
        chk("t2_rec0", qget(0), 1);
        button_raw = 1'b0;
        tick(12);
        chk("t2_deb_low", int'(debounced), 0);

        // 3: short glitches are rejected
        got.delete();
        seen_hi = 0;
        for (int p = 0; p < 5; p++) begin
            button_raw = 1'b1;
            for (int c = 0; c < 7; c++) begin
                tick(1);
                if (debounced) seen_hi = 1;
            end
            button_raw = 1'b0;
            for (int c = 0; c < 7; c++) begin
                tick(1);
                if (debounced) seen_hi = 1;
            end
        end
        tick(12);
        chk("t3_no_rise", seen_hi, 0);
        chk("t3_nrec", got.size(), 0);

        // 4: overflow, drain order, counter keeps counting
        do_reset();
        bus.result_ready = 1'b0;
        for (int p = 0; p < 6; p++) press();
        chk("t4_valid", int'(bus.result_valid), 1);
        chk("t4_head", int'(bus.result_count), 1);
        chk("t4_drop", int'(dropped), 1);
        tick(3);
        chk("t4_hold", int'(bus.result_count), 1);
        bus.result_ready = 1'b1;
        tick(8);
        chk("t4_nrec", got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_rec%0d", i), qget(i), i + 1);
        chk("t4_empty", int'(bus.result_valid), 0);
        chk("t4_drop_sticky", int'(dropped), 1);
        press();
        chk("t4_next", qget(4), 7);

        // 5: counter wrap
        do_reset();
        bus.result_ready = 1'b1;
        for (int p = 0; p < 257; p++) press();
        chk("t5_nrec", got.size(), 257);
        nerr = 0;
        for (int i = 0; i < 257; i++)
            if (qget(i) != ((i + 1) % 256)) nerr++;
        chk("t5_order", nerr, 0);
        chk("t5_255", qget(254), 255);
        chk("t5_0", qget(255), 0);
        chk("t5_1", qget(256), 1);
        chk("t5_drop", int'(dropped), 0);

        // 6: reset mid-stream flushes queue and drop flag
        do_reset();
        bus.result_ready = 1'b0;
        for (int p = 0; p < 5; p++) press();
        chk("t6_valid_pre", int'(bus.result_valid), 1);
        chk("t6_drop_pre", int'(dropped), 1);
        reset = 1'b1;
        tick(1);
        chk("t6_valid", int'(bus.result_valid), 0);
        chk("t6_drop", int'(dropped), 0);
        chk("t6_count", int'(bus.result_count), 0);
        reset = 1'b0;
        got.delete();
        bus.result_ready = 1'b1;
        press();
        chk("t6_nrec", got.size(), 1);
        chk("t6_rec0", qget(0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
